class_binarize_ctrl: RTL and testbench

//  Post-training sequencer that binarizes every trained class hypervector (HV).
//  It sits directly upstream of class_select. It drives binarizing_class_hvs and

---
 rtl/hdc_pkg.sv | 25 ++
 rtl/hv_seg_threshold.sv | 18 +
 rtl/class_binarize_ctrl.sv | 173 +++++++++++++++++
 tb/tb_class_binarize_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared types and constants for the HDC class-memory sequencers.
package hdc_pkg;

    localparam int unsigned CLASS_W = 5;
    // Widest segment index a read tag can carry; covers up to 64 segments per class.
    localparam int unsigned TAG_SEG_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } bin_state_e;

    typedef struct packed {
        logic                 valid;
        logic [CLASS_W-1:0]   cls;
        logic [TAG_SEG_W-1:0] seg;
    } seg_tag_t;

    function automatic logic [5:0] clamp_classes(input logic [5:0] req, input logic [5:0] max);
        return (req > max) ? max : req;
    endfunction

endpackage

// File: rtl/hv_seg_threshold.sv
// Thresholds one accumulator segment: SEG_W parallel signed compares.
module hv_seg_threshold #(
    parameter int unsigned SEG_W = 32,
    parameter int unsigned ACC_W = 8
) (
    input  logic [SEG_W*ACC_W-1:0] seg_data,
    input  logic [ACC_W-1:0]       threshold,
    output logic [SEG_W-1:0]       seg_bits
);

    always_comb begin
        seg_bits = '0;
        for (int i = 0; i < SEG_W; i++) begin
            seg_bits[i] = $signed(seg_data[i*ACC_W +: ACC_W]) >= $signed(threshold);
        end
    end

endmodule

// File: rtl/class_binarize_ctrl.sv
// Post-training sequencer: streams every class HV out of the accumulator memory,
// thresholds it segment by segment and writes the bits to the binary class memory.
module class_binarize_ctrl
    import hdc_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = 32,
    parameter int unsigned SEGS        = 64,
    parameter int unsigned SEG_W       = 32,
    parameter int unsigned ACC_W       = 8,
    parameter int unsigned RD_LAT      = 2,
    localparam int unsigned SEG_AW     = (SEGS > 1) ? $clog2(SEGS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_binarize,
    input  logic [5:0]                num_classes,
    input  logic [ACC_W-1:0]          threshold,
    output logic                      binarizing_class_hvs,
    output logic [CLASS_W-1:0]        binarized_class_counter,
    output logic [SEG_AW-1:0]         seg_rd_addr,
    input  logic [SEG_W*ACC_W-1:0]    seg_rd_data,
    output logic                      bin_wr_en,
    output logic [CLASS_W+SEG_AW-1:0] bin_wr_addr,
    output logic [SEG_W-1:0]          bin_wr_data,
    output logic                      busy,
    output logic                      done
);

    localparam logic [5:0]        NC_MAX   = 6'(NUM_CLASSES);
    localparam logic [SEG_AW-1:0] SEG_LAST = SEG_AW'(SEGS - 1);

    bin_state_e          state_q, state_d;
    logic [CLASS_W-1:0]  cls_q, cls_d;
    logic [CLASS_W-1:0]  last_cls_q, last_cls_d;
    logic [SEG_AW-1:0]   seg_q, seg_d;
    logic [ACC_W-1:0]    thr_q, thr_d;
    logic [5:0]          nc_req;

    seg_tag_t            tag_q [RD_LAT];
    seg_tag_t            tag_in;
    seg_tag_t            tag_out;
    logic                pipe_busy;

    logic                      wr_en_q;
    logic [CLASS_W+SEG_AW-1:0] wr_addr_q;
    logic [SEG_W-1:0]          wr_data_q;
    logic [SEG_W-1:0]          seg_bits;

    assign nc_req = clamp_classes(num_classes, NC_MAX);

    // Next-state logic; class/segment registers drive the read port directly.
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        last_cls_d = last_cls_q;
        seg_d      = seg_q;
        thr_d      = thr_q;
        unique case (state_q)
            IDLE: begin
                if (start_binarize) begin
                    thr_d      = threshold;
                    cls_d      = '0;
                    seg_d      = '0;
                    last_cls_d = CLASS_W'(nc_req - 6'd1);
                    state_d    = (nc_req == 6'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (seg_q == SEG_LAST) begin
                    if (cls_q == last_cls_q) begin
                        state_d = DRAIN;
                    end else begin
                        seg_d = '0;
                        cls_d = cls_q + CLASS_W'(1);
                    end
                end else begin
                    seg_d = seg_q + SEG_AW'(1);
                end
            end
            DRAIN: begin
                // Pipe empty means the final write is on the bus this cycle.
                if (!pipe_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cls_q      <= '0;
            last_cls_q <= '0;
            seg_q      <= '0;
            thr_q      <= '0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            last_cls_q <= last_cls_d;
            seg_q      <= seg_d;
            thr_q      <= thr_d;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = (state_q == ISSUE);
        tag_in.cls   = cls_q;
        tag_in.seg   = TAG_SEG_W'(seg_q);
    end

    // Tags travel alongside the read so the write address lines up with the returned data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            pipe_busy = pipe_busy | tag_q[i].valid;
        end
    end

    assign tag_out = tag_q[RD_LAT-1];

    hv_seg_threshold #(
        .SEG_W (SEG_W),
        .ACC_W (ACC_W)
    ) u_thresh (
        .seg_data  (seg_rd_data),
        .threshold (thr_q),
        .seg_bits  (seg_bits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= tag_out.valid;
            if (tag_out.valid) begin
                wr_addr_q <= {tag_out.cls, tag_out.seg[SEG_AW-1:0]};
                wr_data_q <= seg_bits;
            end
        end
    end

    assign binarizing_class_hvs    = (state_q == ISSUE) || (state_q == DRAIN);
    assign busy                    = (state_q != IDLE);
    assign done                    = (state_q == DONE);
    assign binarized_class_counter = cls_q;
    assign seg_rd_addr             = seg_q;
    assign bin_wr_en               = wr_en_q;
    assign bin_wr_addr             = wr_addr_q;
    assign bin_wr_data             = wr_data_q;

endmodule

// File: tb/tb_class_binarize_ctrl.sv
// Scoreboard bench for class_binarize_ctrl with a small latency-modelled accumulator memory.
module tb_class_binarize_ctrl;

    localparam int unsigned NUM_CLASSES = 32;
    localparam int unsigned SEGS        = 4;
    localparam int unsigned SEG_W       = 8;
    localparam int unsigned ACC_W       = 8;
    localparam int unsigned RD_LAT      = 2;
    localparam int unsigned SEG_AW      = 2;
    localparam int unsigned AW          = 5 + SEG_AW;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   start_binarize = 1'b0;
    logic [5:0]             num_classes = '0;
    logic [ACC_W-1:0]       threshold = '0;
    logic                   binarizing_class_hvs;
    logic [4:0]             binarized_class_counter;
    logic [SEG_AW-1:0]      seg_rd_addr;
    logic [SEG_W*ACC_W-1:0] seg_rd_data;
    logic                   bin_wr_en;
    logic [AW-1:0]          bin_wr_addr;
    logic [SEG_W-1:0]       bin_wr_data;
    logic                   busy;
    logic                   done;

    class_binarize_ctrl #(
        .NUM_CLASSES (NUM_CLASSES),
        .SEGS        (SEGS),
        .SEG_W       (SEG_W),
        .ACC_W       (ACC_W),
        .RD_LAT      (RD_LAT)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .start_binarize          (start_binarize),
        .num_classes             (num_classes),
        .threshold               (threshold),
        .binarizing_class_hvs    (binarizing_class_hvs),
        .binarized_class_counter (binarized_class_counter),
        .seg_rd_addr             (seg_rd_addr),
        .seg_rd_data             (seg_rd_data),
        .bin_wr_en               (bin_wr_en),
        .bin_wr_addr             (bin_wr_addr),
        .bin_wr_data             (bin_wr_data),
        .busy                    (busy),
        .done                    (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;
    int pat_mode = 0;
    int salt     = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [SEG_W-1:0] data;
    } exp_t;
    exp_t exp_q [$];

    logic [25:0] all_outs;
    assign all_outs = {binarizing_class_hvs, binarized_class_counter, seg_rd_addr, bin_wr_en,
                       bin_wr_addr, bin_wr_data, busy, done};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mode 1 repeats the element pattern {-1, 0, 1, 127}.
    function automatic logic [7:0] elem(input int c, input int s, input int i, input int mode,
                                        input int sl);
        if (mode == 1) begin
            case (i % 4)
                0:       return 8'hFF;
                1:       return 8'h00;
                2:       return 8'h01;
                default: return 8'h7F;
            endcase
        end
        return 8'((c * 37 + s * 11 + i * 29 + sl * 53) & 255);
    endfunction

    function automatic logic [SEG_W-1:0] model_bits(input int c, input int s, input logic [7:0] thr,
                                                    input int mode, input int sl);
        logic [SEG_W-1:0] r;
        r = '0;
        for (int i = 0; i < SEG_W; i++) begin
            r[i] = $signed(elem(c, s, i, mode, sl)) >= $signed(thr);
        end
        return r;
    endfunction

    // Accumulator memory: address presented in cycle n, data valid in cycle n+RD_LAT.
    logic [4:0]        rp_cls [RD_LAT];
    logic [SEG_AW-1:0] rp_seg [RD_LAT];

    always @(posedge clk) begin
        rp_cls[0] <= binarized_class_counter;
        rp_seg[0] <= seg_rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            rp_cls[i] <= rp_cls[i-1];
            rp_seg[i] <= rp_seg[i-1];
        end
    end

    always_comb begin
        seg_rd_data = '0;
        for (int i = 0; i < SEG_W; i++) begin
            seg_rd_data[i*ACC_W +: ACC_W] = elem(int'(rp_cls[RD_LAT-1]), int'(rp_seg[RD_LAT-1]),
                                                 i, pat_mode, salt);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (bin_wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bin_wr_addr), 64'(e.addr));
                    check("wr_data", 64'(bin_wr_data), 64'(e.data));
                end
            end
        end
    end

    task automatic push_exp(input int nc_eff, input logic [7:0] thr, input int mode,
                            input logic [SEG_W-1:0] pat_bits);
        for (int c = 0; c < nc_eff; c++) begin
            for (int s = 0; s < int'(SEGS); s++) begin
                exp_t e;
                e.addr = AW'((c << SEG_AW) | s);
                e.data = (mode == 1) ? pat_bits : model_bits(c, s, thr, mode, salt);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_case(input logic [5:0] nc_in, input logic [7:0] thr, input int mode,
                            input logic [SEG_W-1:0] pat_bits, input bit extra_start,
                            input bit start_at_done);
        int nc_eff;
        int n_rd;
        int lat;
        int cycles;
        int first_wr;
        int done0;
        nc_eff   = (nc_in > 6'(NUM_CLASSES)) ? int'(NUM_CLASSES) : int'(nc_in);
        n_rd     = nc_eff * int'(SEGS);
        lat      = (nc_eff == 0) ? 1 : n_rd + int'(RD_LAT) + 2;
        first_wr = 0;
        salt++;
        pat_mode = mode;
        push_exp(nc_eff, thr, mode, pat_bits);
        wr_cnt = 0;
        done0  = done_cnt;

        start_binarize = 1'b1;
        num_classes    = nc_in;
        threshold      = thr;
        @(negedge clk);
        start_binarize = 1'b0;
        // Latched values must not follow the live inputs.
        num_classes    = 6'd1;
        threshold      = thr ^ 8'h80;
        cycles         = 1;
        while (done !== 1'b1 && cycles <= lat + 8) begin
            if (cycles <= n_rd) begin
                check("rd_addr", 64'({binarized_class_counter, seg_rd_addr}),
                      64'((((cycles - 1) / int'(SEGS)) << SEG_AW) | ((cycles - 1) % int'(SEGS))));
            end else begin
                check("drain_cls", 64'(binarized_class_counter), 64'(nc_eff - 1));
            end
            check("bin_hvs", 64'(binarizing_class_hvs), 64'(cycles < lat));
            if (bin_wr_en && first_wr == 0) first_wr = cycles;
            if (extra_start && cycles == 3) begin
                start_binarize = 1'b1;
                num_classes    = 6'd5;
            end else begin
                start_binarize = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start_binarize = 1'b0;
        check("done_lat", 64'(cycles), 64'(lat));
        check("done_busy", 64'(busy), 64'd1);
        check("done_hvs", 64'(binarizing_class_hvs), 64'd0);
        if (nc_eff > 0) check("first_wr", 64'(first_wr), 64'(RD_LAT + 2));
        if (start_at_done) begin
            start_binarize = 1'b1;
            num_classes    = 6'd2;
        end
        @(negedge clk);
        start_binarize = 1'b0;
        check("done_pulse", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        check("wr_count", 64'(wr_cnt), 64'(n_rd));
        repeat (3) @(negedge clk);
        check("done_count", 64'(done_cnt - done0), 64'd1);
        check("stay_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_outs", 64'(all_outs), 64'd0);
        repeat (2) @(negedge clk);
        check("rst_outs_clk", 64'(all_outs), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_case(6'd2, 8'h10, 0, '0, 1'b0, 1'b0);
        run_case(6'd1, 8'h00, 1, 8'hEE, 1'b0, 1'b0);
        run_case(6'd1, 8'h80, 1, 8'hFF, 1'b0, 1'b0);
        run_case(6'd3, 8'hFB, 0, '0, 1'b1, 1'b0);
        run_case(6'd0, 8'h00, 0, '0, 1'b0, 1'b0);
        run_case(6'd2, 8'h80, 0, '0, 1'b0, 1'b1);
        run_case(6'd1, 8'h05, 0, '0, 1'b0, 1'b0);

        // Abort mid-issue; outputs clear asynchronously.
        salt++;
        pat_mode = 0;
        push_exp(3, 8'h00, 0, '0);
        start_binarize = 1'b1;
        num_classes    = 6'd3;
        threshold      = 8'h00;
        @(negedge clk);
        start_binarize = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", 64'(all_outs), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_case(6'd2, 8'h20, 0, '0, 1'b0, 1'b0);

        run_case(6'd40, 8'h80, 0, '0, 1'b0, 1'b0);
        run_case(6'd33, 8'h30, 0, '0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
